// File: rtl/softmax_drv.sv
// Host-side driver for the 4-lane fp16 softmax block: packs a serial input stream, starts the
// block, waits a fixed latency and serialises the results. Optional max broadcast: SOFTMAX_DRV_MAXSUB_EN.
module softmax_drv #(
  parameter int DATAWIDTH = 16,
  parameter int NUM       = 4,
  parameter int LATENCY   = 40
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATAWIDTH-1:0]     in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATAWIDTH*NUM-1:0] inp,
  output logic [DATAWIDTH*NUM-1:0] sub0_inp,
  output logic [DATAWIDTH*NUM-1:0] sub1_inp,
  output logic                     start,
  input  logic [DATAWIDTH-1:0]     outp0,
  input  logic [DATAWIDTH-1:0]     outp1,
  input  logic [DATAWIDTH-1:0]     outp2,
  input  logic [DATAWIDTH-1:0]     outp3,
  output logic [DATAWIDTH-1:0]     out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                   state_r, state_nxt_s;
  logic [1:0]               idx_r, idx_nxt_s;
  logic [1:0]               j_r, j_nxt_s;
  logic [CW-1:0]            cnt_r, cnt_nxt_s;
  logic [DATAWIDTH*NUM-1:0] inp_r;
  logic [DATAWIDTH-1:0]     res_r     [0:3];
  logic [DATAWIDTH-1:0]     res_nxt_s [0:3];
  logic                     accept_s, beat_s, capture_s;
  logic                     in_ready_r, start_r, out_valid_r, out_last_r, busy_r;
  logic [DATAWIDTH-1:0]     out_data_r;

  assign accept_s  = (state_r == ST_FILL) && in_valid;
  assign beat_s    = (state_r == ST_DRAIN) && out_ready;
  assign capture_s = (state_r == ST_WAIT) && (cnt_r == {CW{1'b0}});

  // Next-state, index and latency counter decode
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    j_nxt_s     = j_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_FILL: begin
        if (accept_s) begin
          idx_nxt_s = idx_r + 2'd1;
          if (idx_r == 2'd3) begin
            state_nxt_s = ST_START;
          end else begin
            state_nxt_s = ST_FILL;
          end
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      ST_START: begin
        cnt_nxt_s   = CNT_LOAD;
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (capture_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          cnt_nxt_s = cnt_r - CW'(1);
        end
      end
      ST_DRAIN: begin
        if (beat_s) begin
          j_nxt_s = j_r + 2'd1;
          if (j_r == 2'd3) begin
            state_nxt_s = ST_FILL;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end else begin
          j_nxt_s = j_r;
        end
      end
      default: begin
        state_nxt_s = ST_FILL;
        idx_nxt_s   = 2'd0;
        j_nxt_s     = 2'd0;
        cnt_nxt_s   = {CW{1'b0}};
      end
    endcase
  end

  // Result capture mux: outp* are taken in the cycle the counter reaches zero
  always_comb begin
    res_nxt_s[0] = res_r[0];
    res_nxt_s[1] = res_r[1];
    res_nxt_s[2] = res_r[2];
    res_nxt_s[3] = res_r[3];
    if (capture_s) begin
      res_nxt_s[0] = outp0;
      res_nxt_s[1] = outp1;
      res_nxt_s[2] = outp2;
      res_nxt_s[3] = outp3;
    end else begin
      res_nxt_s[0] = res_r[0];
    end
  end

  // Control state, counters and result storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_FILL;
      idx_r   <= 2'd0;
      j_r     <= 2'd0;
      cnt_r   <= {CW{1'b0}};
      for (int k = 0; k < 4; k++) begin
        res_r[k] <= {DATAWIDTH{1'b0}};
      end
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      j_r     <= j_nxt_s;
      cnt_r   <= cnt_nxt_s;
      for (int k = 0; k < 4; k++) begin
        res_r[k] <= res_nxt_s[k];
      end
    end
  end

  // Packed input vector: one lane written per accepted beat
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inp_r <= {(DATAWIDTH*NUM){1'b0}};
    end else if (accept_s) begin
      inp_r[int'(idx_r)*DATAWIDTH +: DATAWIDTH] <= in_data;
    end else begin
      inp_r <= inp_r;
    end
  end

  // Outputs registered from next-state values so they line up with the state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready_r  <= 1'b1;
      start_r     <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      out_data_r  <= {DATAWIDTH{1'b0}};
    end else begin
      in_ready_r  <= (state_nxt_s == ST_FILL);
      start_r     <= (state_nxt_s == ST_START);
      out_valid_r <= (state_nxt_s == ST_DRAIN);
      out_last_r  <= (state_nxt_s == ST_DRAIN) && (j_nxt_s == 2'd3);
      busy_r      <= (state_nxt_s != ST_FILL) || (idx_nxt_s != 2'd0);
      out_data_r  <= res_nxt_s[j_nxt_s];
    end
  end

  assign in_ready  = in_ready_r;
  assign start     = start_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign out_data  = out_data_r;
  assign inp       = inp_r;

`ifdef SOFTMAX_DRV_MAXSUB_EN
  logic [DATAWIDTH-1:0]     mx_r, mx_nxt_s;
  logic [DATAWIDTH*NUM-1:0] sub_r;

  // Order-preserving key: negatives fully inverted, positives get the sign bit set
  function automatic logic [DATAWIDTH-1:0] key_f(input logic [DATAWIDTH-1:0] v);
    logic [DATAWIDTH-1:0] k;
    if (v[DATAWIDTH-1]) begin
      k = ~v;
    end else begin
      k = {1'b1, v[DATAWIDTH-2:0]};
    end
    return k;
  endfunction

  // Running maximum of the current vector
  always_comb begin
    mx_nxt_s = mx_r;
    if (accept_s) begin
      if (idx_r == 2'd0) begin
        mx_nxt_s = in_data;
      end else if (key_f(in_data) > key_f(mx_r)) begin
        mx_nxt_s = in_data;
      end else begin
        mx_nxt_s = mx_r;
      end
    end else begin
      mx_nxt_s = mx_r;
    end
  end

  // Maximum register and its lane broadcast
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mx_r  <= {DATAWIDTH{1'b0}};
      sub_r <= {(DATAWIDTH*NUM){1'b0}};
    end else if (accept_s) begin
      mx_r  <= mx_nxt_s;
      sub_r <= {NUM{mx_nxt_s}};
    end else begin
      mx_r  <= mx_r;
      sub_r <= sub_r;
    end
  end

  assign sub0_inp = sub_r;
  assign sub1_inp = sub_r;
`else
  assign sub0_inp = inp_r;
  assign sub1_inp = inp_r;
`endif

endmodule

// File: tb/tb_softmax_drv.sv
// Self-checking bench for softmax_drv: table vectors, randomized vectors against a reference
// model, reset and minimum-latency sequences.
module tb_softmax_drv;

  localparam int LAT8 = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready, start, out_valid, out_last, busy;
  logic [63:0] inp, sub0_inp, sub1_inp;
  logic [15:0] out_data;

  logic [15:0] in_data1 = 16'h0000;
  logic        in_valid1 = 1'b0;
  logic        out_ready1 = 1'b1;
  logic        in_ready1, start1, out_valid1, out_last1, busy1;
  logic [63:0] inp1, sub0_inp1, sub1_inp1;
  logic [15:0] out_data1;

  logic [63:0] outp_v = 64'h0;
  logic [63:0] outp_log [0:4095];
  int          edge_n = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  softmax_drv #(.DATAWIDTH(16), .NUM(4), .LATENCY(LAT8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .inp(inp), .sub0_inp(sub0_inp), .sub1_inp(sub1_inp), .start(start),
    .outp0(outp_v[15:0]), .outp1(outp_v[31:16]), .outp2(outp_v[47:32]), .outp3(outp_v[63:48]),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy)
  );

  softmax_drv #(.DATAWIDTH(16), .NUM(4), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .inp(inp1), .sub0_inp(sub0_inp1), .sub1_inp(sub1_inp1), .start(start1),
    .outp0(outp_v[15:0]), .outp1(outp_v[31:16]), .outp2(outp_v[47:32]), .outp3(outp_v[63:48]),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1), .out_last(out_last1),
    .busy(busy1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Fresh softmax results every cycle, remembered by the edge at which they are present
  always @(negedge clk) begin
    logic [63:0] v;
    v = {$urandom, $urandom};
    outp_v <= v;
    outp_log[(edge_n + 1) % 4096] <= v;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  // Reference: numeric ordering of fp16 values, -0 just below +0
  function automatic int ord(input logic [15:0] v);
    int mag;
    mag = int'({17'b0, v[14:0]});
    return v[15] ? (-mag - 1) : mag;
  endfunction

  function automatic logic [15:0] ref_max(input logic [63:0] ev);
    logic [15:0] m, e;
    m = ev[15:0];
    for (int k = 1; k < 4; k++) begin
      e = ev[16*k +: 16];
      if (ord(e) > ord(m)) m = e;
    end
    return m;
  endfunction

  function automatic logic [63:0] ref_sub(input logic [63:0] exp_inp, input logic [15:0] mx);
`ifdef SOFTMAX_DRV_MAXSUB_EN
    return {4{mx}};
`else
    return exp_inp;
`endif
  endfunction

  function automatic logic [63:0] ref_pack(input logic [15:0] e0, input logic [15:0] e1,
                                           input logic [15:0] e2, input logic [15:0] e3);
    logic [63:0] p;
    p = 64'h0;
    p[15:0] = e0; p[31:16] = e1; p[47:32] = e2; p[63:48] = e3;
    return p;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_inp"}, inp, 0);
    chk({tag, "_sub0"}, sub0_inp, 0);
    chk({tag, "_sub1"}, sub1_inp, 0);
    chk({tag, "_out_data"}, out_data, 0);
  endtask

  // Feeds n elements to the LATENCY=8 instance, positioned at a negedge
  task automatic feed(input logic [63:0] ev, input int n);
    for (int k = 0; k < n; k++) begin
      in_data = ev[16*k +: 16];
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // One full transaction on the LATENCY=8 instance with all cycle-level checks
  task automatic run_vec(input string tag, input logic [63:0] ev, input logic [63:0] exp_inp,
                         input logic [15:0] exp_mx, input int gap_pos, input int gap_len,
                         input int stall, input bit junk);
    int acc, n, extra_start, inp_bad;
    logic [63:0] exp_res, exp_sub;
    acc = 0;
    exp_sub = ref_sub(exp_inp, exp_mx);
    for (int k = 0; k < 4; k++) begin
      if (k == gap_pos) begin
        in_valid = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          chk({tag, "_gap_start"}, start, 0);
          chk({tag, "_gap_busy"}, busy, (k > 0) ? 1 : 0);
        end
      end
      in_data = ev[16*k +: 16];
      in_valid = 1'b1;
      chk({tag, "_in_ready"}, in_ready, 1);
      acc = edge_n + 1;
      @(negedge clk);
    end
    if (junk) begin
      in_valid = 1'b1;
      in_data = 16'(($urandom));
    end else begin
      in_valid = 1'b0;
    end
    chk({tag, "_start_pulse"}, start, 1);
    chk({tag, "_start_in_ready"}, in_ready, 0);
    chk({tag, "_start_busy"}, busy, 1);
    chk({tag, "_inp"}, inp, exp_inp);
    chk({tag, "_sub0"}, sub0_inp, exp_sub);
    chk({tag, "_sub1"}, sub1_inp, exp_sub);
    n = 0; extra_start = 0; inp_bad = 0;
    do begin
      @(negedge clk);
      n++;
      if (start) extra_start++;
      if (inp !== exp_inp || sub0_inp !== exp_sub) inp_bad++;
    end while (!out_valid && n < 200);
    chk({tag, "_out_valid_timeout"}, out_valid, 1);
    chk({tag, "_extra_start"}, extra_start, 0);
    chk({tag, "_inputs_stable"}, inp_bad, 0);
    chk({tag, "_latency_edge"}, edge_n, acc + 1 + LAT8);
    exp_res = outp_log[(acc + 1 + LAT8) % 4096];
    if (stall > 0) begin
      out_ready = 1'b0;
      extra_start = 0; inp_bad = 0;
      for (int s = 0; s < stall; s++) begin
        if (start) extra_start++;
        if (!out_valid || out_data !== exp_res[15:0] || out_last || in_ready) inp_bad++;
        @(negedge clk);
      end
      chk({tag, "_stall_stable"}, inp_bad, 0);
      chk({tag, "_stall_start"}, extra_start, 0);
      out_ready = 1'b1;
    end
    for (int l = 0; l < 4; l++) begin
      chk({tag, "_lane_valid"}, out_valid, 1);
      chk({tag, "_lane_data"}, out_data, exp_res[16*l +: 16]);
      chk({tag, "_lane_last"}, out_last, (l == 3) ? 1 : 0);
      chk({tag, "_lane_in_ready"}, in_ready, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk({tag, "_post_in_ready"}, in_ready, 1);
    chk({tag, "_post_out_valid"}, out_valid, 0);
    chk({tag, "_post_busy"}, busy, 0);
  endtask

  typedef struct {
    logic [63:0] ev;
    logic [63:0] exp_inp;
    logic [15:0] exp_mx;
    int          gap_pos;
    int          gap_len;
    int          stall;
    bit          junk;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int acc, cnt_bad;
    logic [63:0] ev, er;
    logic [15:0] e [4];

    tbl[0] = '{64'h993e_4210_4040_3800, 64'h993e_4210_4040_3800, 16'h4210, 9, 0, 0, 1'b0};
    tbl[1] = '{64'hc200_b800_c000_bc00, 64'hc200_b800_c000_bc00, 16'hb800, 2, 3, 0, 1'b0};
    tbl[2] = '{64'h0001_7c00_8000_0000, 64'h0001_7c00_8000_0000, 16'h7c00, 9, 0, 10, 1'b1};
    tbl[3] = '{64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000, 16'h8000, 1, 1, 2, 1'b0};

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run_vec($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].exp_inp, tbl[i].exp_mx,
              tbl[i].gap_pos, tbl[i].gap_len, tbl[i].stall, tbl[i].junk);
    end

    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 4; k++) e[k] = 16'($urandom);
      ev = ref_pack(e[0], e[1], e[2], e[3]);
      run_vec($sformatf("rnd%0d", r), ev, ev, ref_max(ev), $urandom_range(0, 4),
              $urandom_range(1, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset after two accepted elements
    feed(64'h1111_2222_3333_4444, 2);
    chk("rst_fill_busy", busy, 1);
    reset = 1'b0;
    #1;
    check_reset_vals("rst_fill");
    @(negedge clk);
    reset = 1'b1;
    cnt_bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (start || out_valid || busy) cnt_bad++;
    end
    chk("rst_fill_quiet", cnt_bad, 0);
    run_vec("after_rst_fill", 64'h4400_4200_4000_3c00, 64'h4400_4200_4000_3c00, 16'h4400,
            9, 0, 0, 1'b0);

    // Reset during WAIT
    feed(64'h5555_6666_7777_0123, 4);
    repeat (3) @(negedge clk);
    chk("rst_wait_busy", busy, 1);
    reset = 1'b0;
    #1;
    check_reset_vals("rst_wait");
    @(negedge clk);
    reset = 1'b1;
    cnt_bad = 0;
    for (int c = 0; c < LAT8 + 10; c++) begin
      @(negedge clk);
      if (start || out_valid || busy) cnt_bad++;
    end
    chk("rst_wait_quiet", cnt_bad, 0);
    run_vec("after_rst_wait", 64'h3c00_bc00_0000_8000, 64'h3c00_bc00_0000_8000, 16'h3c00,
            9, 0, 0, 1'b0);

    // Minimum latency instance
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      in_data1 = 16'h2000 + 16'(k);
      in_valid1 = 1'b1;
      chk("lat1_in_ready", in_ready1, 1);
      acc = edge_n + 1;
      @(negedge clk);
    end
    in_valid1 = 1'b0;
    chk("lat1_start", start1, 1);
    chk("lat1_inp", inp1, 64'h2003_2002_2001_2000);
    @(negedge clk);
    chk("lat1_start_off", start1, 0);
    chk("lat1_no_valid_yet", out_valid1, 0);
    @(negedge clk);
    chk("lat1_valid", out_valid1, 1);
    er = outp_log[(acc + 2) % 4096];
    for (int l = 0; l < 4; l++) begin
      chk("lat1_lane_data", out_data1, er[16*l +: 16]);
      chk("lat1_lane_last", out_last1, (l == 3) ? 1 : 0);
      @(negedge clk);
    end
    chk("lat1_post_in_ready", in_ready1, 1);
    chk("lat1_post_valid", out_valid1, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/softmax_drv.md
# softmax_drv

Host-side driver for the 4-lane fp16 `softmax` block. It accepts fp16 elements one at a time on a valid/ready stream and packs them into the `inp`, `sub0_inp` and `sub1_inp` vectors. It then pulses `start` for one cycle and waits a fixed compute latency. Finally it captures `outp0..outp3` and returns them serially on a valid/ready output stream.

## Interface
Parameters:
- `DATAWIDTH`, 16: element width (IEEE fp16).
- `NUM`, 4: lanes per softmax vector. Fixed at 4 because the output ports are `outp0..outp3`.
- `LATENCY`, 40: cycles from the `start` cycle to valid softmax outputs. Must be ≥1.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  DATAWIDTH  fp16 element.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  driver accepts an element (FILL state only).
- `inp`  out  DATAWIDTH*NUM  packed softmax input; element k occupies bits [16k+15:16k].
- `sub0_inp`  out  DATAWIDTH*NUM  softmax subtrahend vector 0.
- `sub1_inp`  out  DATAWIDTH*NUM  softmax subtrahend vector 1.
- `start`  out  1  one-cycle softmax start pulse.
- `outp0`..`outp3`  in  DATAWIDTH each  softmax results.
- `out_data`  out  DATAWIDTH  result element.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts `out_data`.
- `out_last`  out  1  high with lane 3 of `out_data`.
- `busy`  out  1  state is not FILL, or the element index is nonzero.

## Operation
States:
- **FILL**
  - `in_ready`=1.
  - Each beat with `in_valid`&`in_ready` writes `in_data` into lane `idx` of `inp`, then increments the 2-bit `idx`.
  - Acceptance with `idx`==3 wraps `idx` to 0 and moves to START.
- **START**
  - `start`=1 for exactly one cycle; `in_ready`=0.
  - The latency counter loads `LATENCY`-1.
  - Next state is WAIT.
- **WAIT**
  - The counter decrements each cycle.
  - In the cycle the counter equals 0, `outp0..3` are registered into `res[0..3]` and the state moves to DRAIN.
- **DRAIN**
  - `out_valid`=1 and `out_data`=`res[j]`.
  - Each `out_valid`&`out_ready` beat increments `j`.
  - `out_last`=(j==3).
  - The beat that accepts j==3 returns to FILL with `j`=0.

Rules:
- There is no overlap between vectors: `in_ready`=0 in START, WAIT and DRAIN.
- `inp`, `sub0_inp` and `sub1_inp` change only on accepted FILL beats. They stay stable from START through the end of WAIT.
- `out_data` and `out_last` stay stable while `out_valid`=1 and `out_ready`=0.
- Data passes through bit-exact. No fp arithmetic is performed except the optional max compare (see Configuration).

## Timing
Reset values (assert `reset`=0):
- State FILL, `idx`=0, `j`=0, counter 0.
- `inp`, `sub0_inp`, `sub1_inp` and `res` = 0.
- `start`=0, `out_valid`=0, `out_last`=0, `in_ready`=1, `busy`=0.

Cycle-level latencies:
- The 4th element is accepted at edge t. `start` is high in cycle t+1 only.
- `outp*` are sampled at the edge ending cycle t+1+`LATENCY`.
- `out_valid` rises in cycle t+2+`LATENCY`.
- With `out_ready` held high, lanes 0..3 appear on 4 consecutive cycles. `in_ready` is 1 in the cycle after the lane-3 beat.

Boundary conditions:
- `in_valid` gaps during FILL: `idx` holds and no partial vector is issued.
- `in_valid` high outside FILL: ignored, not consumed.
- `out_ready` low in DRAIN: the driver stalls indefinitely; the counter and inputs are unaffected.
- Reset mid-operation, in any state: immediate return to reset values. A partially filled vector is discarded and any pending results are lost.
- `LATENCY`=1: samples `outp*` at the edge ending the cycle after the `start` cycle.

## Configuration
- `SOFTMAX_DRV_MAXSUB_EN` undefined: `sub0_inp` = `sub1_inp` = `inp` at all times.
- `SOFTMAX_DRV_MAXSUB_EN` defined:
  - A register `mx` tracks the maximum accepted element of the current vector.
  - The first element of each vector loads `mx` unconditionally. Later elements replace `mx` when they compare greater.
  - Compare key: if the sign bit is 1, invert all bits; otherwise flip only the sign bit. Keys are compared unsigned, so -0 < +0. NaN gets no special handling.
  - `sub0_inp` and `sub1_inp` carry `mx` broadcast to all 4 lanes, registered and valid from the START cycle.
  - Reset clears `mx` to 0.

## Test plan
1. **Basic vector.** Reset low then high, `LATENCY`=8. Feed 0x3800, 0x4040, 0x4210, 0x993e back-to-back.
   - Required: `inp`=0x993e_4210_4040_3800.
   - Required: a single 1-cycle `start` in the cycle after the 4th beat.
   - Required: `outp*` sampled 8 cycles after the `start` cycle. Output lanes 0..3 match `outp0..3`, with `out_last` on lane 3.
2. **MAXSUB.** Same stimulus with `SOFTMAX_DRV_MAXSUB_EN` defined -> `sub0_inp`=`sub1_inp`=0x4210_4210_4210_4210.
   - Second vector 0xbc00, 0xc000, 0xb800, 0xc200 -> broadcast value 0xb800.
3. **Input gaps.** Drop `in_valid` for 3 cycles between elements 2 and 3 -> no `start` until the 4th beat. `idx` holds and lane placement is unchanged.
4. **Output backpressure.** Hold `out_ready`=0 for 10 cycles in DRAIN.
   - Required: `out_valid` and `out_data` stable, `in_ready`=0, no second `start`.
   - Required: after release, exactly 4 beats, then `in_ready`=1.
5. **Reset mid-operation.** Assert reset after 2 elements accepted, and separately during WAIT.
   - Required: all outputs return to reset values, no `start` and no `out_valid` afterwards.
   - Required: the next 4 elements fill lanes 0..3 normally.
6. **Minimum latency.** `LATENCY`=1 -> `outp*` sampled at the edge ending the cycle after `start`, and `out_valid` rises 2 cycles after `start`.
